// File: rtl/ddr_lane_model_pkg.sv
// Shared types and helpers for the DDR lane board-trace model.
package ddr_lane_model_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        TURN = 2'd3
    } dir_e;

    localparam int CNT_W = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ddr_lane_delay_pipe.sv
// Fixed-depth data+valid delay line; data is zeroed whenever its valid is low.
module ddr_lane_delay_pipe #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_vld,
    output logic [W-1:0] out_data,
    output logic         out_vld,
    output logic         empty
);

    logic [W-1:0]     data_p [DEPTH];
    logic [DEPTH-1:0] vld_p;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p <= '0;
            for (int i = 0; i < DEPTH; i++) data_p[i] <= '0;
        end else begin
            vld_p[0]  <= in_vld;
            data_p[0] <= in_vld ? in_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i]  <= vld_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign out_data = data_p[DEPTH-1];
    assign out_vld  = vld_p[DEPTH-1];
    assign empty    = ~|vld_p;

endmodule

// File: rtl/ddr_lane_delay_model.sv
// Clocked bidirectional DQ-lane trace model: per-direction delay, direction FSM, contention tracking.
// Optional read-path bit-error injection is built when DDR_LANE_DELAY_ERR_INSERT_EN is defined.
module ddr_lane_delay_model
    import ddr_lane_model_pkg::*;
#(
    parameter int LANES    = 8,
    parameter int DLY_WR   = 2,
    parameter int DLY_RD   = 2,
    parameter int TURN_CYC = 1,
    parameter int ERR_LANE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             phy_init_done,
    input  logic [LANES-1:0] fpga_o,
    input  logic             fpga_oe,
    output logic [LANES-1:0] fpga_i,
    output logic             fpga_i_vld,
    input  logic [LANES-1:0] mem_o,
    input  logic             mem_oe,
    output logic [LANES-1:0] mem_i,
    output logic             mem_i_vld,
    output logic [1:0]       dir,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    if (DLY_WR < 1) begin : g_bad_dly_wr
        $error("DLY_WR must be >= 1");
    end
    if (DLY_RD < 1) begin : g_bad_dly_rd
        $error("DLY_RD must be >= 1");
    end
    if (ERR_LANE >= LANES) begin : g_bad_err_lane
        $error("ERR_LANE must be < LANES");
    end

    localparam int TCW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [TCW-1:0] TURN_LAST = TCW'(TURN_CYC - 1);

`ifdef DDR_LANE_DELAY_ERR_INSERT_EN
    // Extra MSB tags the first beat of each read burst as it travels down the pipe.
    localparam int RD_W = LANES + 1;
`else
    localparam int RD_W = LANES;
`endif

    dir_e           state_q, state_d;
    logic [TCW-1:0] turn_cnt_q;
    logic           wr_push_vld, rd_push_vld, conflict_now;
    logic           wr_empty, rd_empty, rd_out_vld;
    logic [RD_W-1:0] rd_in, rd_out;

    always_comb begin
        state_d      = state_q;
        wr_push_vld  = 1'b0;
        rd_push_vld  = 1'b0;
        conflict_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (fpga_oe) begin
                    wr_push_vld  = 1'b1;
                    conflict_now = mem_oe;
                    state_d      = WR;
                end else if (mem_oe) begin
                    rd_push_vld = 1'b1;
                    state_d     = RD;
                end
            end
            WR: begin
                wr_push_vld  = fpga_oe;
                conflict_now = mem_oe;
                if (!fpga_oe && wr_empty) state_d = (TURN_CYC == 0) ? IDLE : TURN;
            end
            RD: begin
                rd_push_vld  = mem_oe;
                conflict_now = fpga_oe;
                if (!mem_oe && rd_empty) state_d = (TURN_CYC == 0) ? IDLE : TURN;
            end
            TURN: begin
                conflict_now = fpga_oe | mem_oe;
                if (turn_cnt_q == TURN_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Conflict is registered so the pulse lines up with the updated count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            turn_cnt_q   <= '0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state_q    <= state_d;
            turn_cnt_q <= (state_q == TURN) ? turn_cnt_q + 1'b1 : '0;
            conflict   <= conflict_now;
            if (conflict_now) conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

    assign dir = state_q;

    ddr_lane_delay_pipe #(.W(LANES), .DEPTH(DLY_WR)) u_wr_pipe (
        .clock    (clock),
        .reset    (reset),
        .in_data  (fpga_o),
        .in_vld   (wr_push_vld),
        .out_data (mem_i),
        .out_vld  (mem_i_vld),
        .empty    (wr_empty)
    );

    ddr_lane_delay_pipe #(.W(RD_W), .DEPTH(DLY_RD)) u_rd_pipe (
        .clock    (clock),
        .reset    (reset),
        .in_data  (rd_in),
        .in_vld   (rd_push_vld),
        .out_data (rd_out),
        .out_vld  (rd_out_vld),
        .empty    (rd_empty)
    );

    assign fpga_i_vld = rd_out_vld;

`ifdef DDR_LANE_DELAY_ERR_INSERT_EN
    localparam logic [LANES-1:0] ERR_MASK = LANES'(1) << ERR_LANE;

    logic rd_push_prev_q, rd_first, inject;

    assign rd_first = rd_push_vld & ~rd_push_prev_q;
    assign rd_in    = {rd_first, mem_o};
    assign inject   = rd_out_vld & rd_out[LANES] & phy_init_done;
    assign fpga_i   = rd_out[LANES-1:0] ^ (inject ? ERR_MASK : '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_push_prev_q <= 1'b0;
            err_cnt        <= '0;
        end else begin
            rd_push_prev_q <= rd_push_vld;
            if (inject) err_cnt <= sat_inc(err_cnt);
        end
    end
`else
    logic unused_phy_init_done;

    assign unused_phy_init_done = phy_init_done;
    assign rd_in   = mem_o;
    assign fpga_i  = rd_out;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr_lane_delay_model.sv
// Bench for ddr_lane_delay_model: directed vector table, hand sequences, randomized run vs. reference model.
module tb_ddr_lane_delay_model;

    localparam int LANES    = 8;
    localparam int DLY_WR   = 2;
    localparam int DLY_RD   = 3;
    localparam int TURN_CYC = 2;
    localparam int ERR_LANE = 3;
    localparam int SL       = 64;
`ifdef DDR_LANE_DELAY_ERR_INSERT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       phy_init_done = 1'b0;
    logic [7:0] fpga_o = '0, mem_o = '0;
    logic       fpga_oe = 1'b0, mem_oe = 1'b0;
    logic [7:0] fpga_i, mem_i, conflict_cnt, err_cnt;
    logic       fpga_i_vld, mem_i_vld, conflict;
    logic [1:0] dir;

    int n_tests = 0;
    int n_fail  = 0;

    ddr_lane_delay_model #(
        .LANES(LANES), .DLY_WR(DLY_WR), .DLY_RD(DLY_RD), .TURN_CYC(TURN_CYC), .ERR_LANE(ERR_LANE)
    ) dut (
        .clock(clock), .reset(reset), .phy_init_done(phy_init_done),
        .fpga_o(fpga_o), .fpga_oe(fpga_oe), .fpga_i(fpga_i), .fpga_i_vld(fpga_i_vld),
        .mem_o(mem_o), .mem_oe(mem_oe), .mem_i(mem_i), .mem_i_vld(mem_i_vld),
        .dir(dir), .conflict(conflict), .conflict_cnt(conflict_cnt), .err_cnt(err_cnt)
    );

    always #5 clock = ~clock;

    // Reference model: scheduled deliveries indexed by cycle, direction tracked by timestamps.
    int         m_t, m_mode, m_last, m_turn, m_ccnt, m_ecnt;
    bit         m_prev_rd, m_conf;
    bit         wr_v [SL];
    bit         rd_v [SL];
    bit         rd_f [SL];
    logic [7:0] wr_d [SL];
    logic [7:0] rd_d [SL];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (model cycle %0d)", name, act, exp, m_t);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SL; i++) begin
            wr_v[i] = 0; rd_v[i] = 0; rd_f[i] = 0; wr_d[i] = '0; rd_d[i] = '0;
        end
        m_mode = 0; m_last = 0; m_turn = 0; m_ccnt = 0; m_ecnt = 0;
        m_prev_rd = 0; m_conf = 0;
    endtask

    function automatic logic [7:0] exp_fpga_i();
        int s = m_t % SL;
        if (!rd_v[s]) return 8'h00;
        if (INJ && rd_f[s] && phy_init_done) return rd_d[s] ^ (8'h01 << ERR_LANE);
        return rd_d[s];
    endfunction

    task automatic model_check();
        int s = m_t % SL;
        chk("mem_i_vld", mem_i_vld, wr_v[s]);
        chk("mem_i", mem_i, wr_v[s] ? wr_d[s] : 8'h00);
        chk("fpga_i_vld", fpga_i_vld, rd_v[s]);
        chk("fpga_i", fpga_i, exp_fpga_i());
        chk("dir", dir, m_mode);
        chk("conflict", conflict, m_conf);
        chk("conflict_cnt", conflict_cnt, m_ccnt);
        chk("err_cnt", err_cnt, m_ecnt);
    endtask

    task automatic model_step();
        int s = m_t % SL;
        bit wacc = 0, racc = 0, conf = 0;
        if (INJ && rd_v[s] && rd_f[s] && phy_init_done && m_ecnt < 255) m_ecnt++;
        wr_v[s] = 0; rd_v[s] = 0; rd_f[s] = 0;
        case (m_mode)
            0: begin
                if (fpga_oe) begin wacc = 1; conf = mem_oe; m_mode = 1; end
                else if (mem_oe) begin racc = 1; m_mode = 2; end
            end
            1: begin
                conf = mem_oe;
                if (fpga_oe) wacc = 1;
                else if (m_t > m_last + DLY_WR) begin
                    m_mode = (TURN_CYC == 0) ? 0 : 3; m_turn = TURN_CYC;
                end
            end
            2: begin
                conf = fpga_oe;
                if (mem_oe) racc = 1;
                else if (m_t > m_last + DLY_RD) begin
                    m_mode = (TURN_CYC == 0) ? 0 : 3; m_turn = TURN_CYC;
                end
            end
            default: begin
                conf = fpga_oe | mem_oe;
                m_turn--;
                if (m_turn == 0) m_mode = 0;
            end
        endcase
        if (wacc) begin
            wr_v[(m_t + DLY_WR) % SL] = 1; wr_d[(m_t + DLY_WR) % SL] = fpga_o; m_last = m_t;
        end
        if (racc) begin
            rd_v[(m_t + DLY_RD) % SL] = 1; rd_d[(m_t + DLY_RD) % SL] = mem_o;
            rd_f[(m_t + DLY_RD) % SL] = !m_prev_rd; m_last = m_t;
        end
        m_prev_rd = racc;
        m_conf = conf;
        if (conf && m_ccnt < 255) m_ccnt++;
        m_t++;
    endtask

    // Called just after a rising edge: apply inputs, then wait for the sampling edge.
    task automatic drive(input logic foe, input logic [7:0] fo, input logic moe, input logic [7:0] mo);
        fpga_oe = foe; fpga_o = fo; mem_oe = moe; mem_o = mo;
        @(negedge clock);
    endtask

    task automatic finish_cycle();
        model_check();
        model_step();
        @(posedge clock); #1;
    endtask

    task automatic cycle(input logic foe, input logic [7:0] fo, input logic moe, input logic [7:0] mo);
        drive(foe, fo, moe, mo);
        finish_cycle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_i"}, mem_i, 0);
        chk({tag, "_mem_i_vld"}, mem_i_vld, 0);
        chk({tag, "_fpga_i"}, fpga_i, 0);
        chk({tag, "_fpga_i_vld"}, fpga_i_vld, 0);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_conflict"}, conflict, 0);
        chk({tag, "_conflict_cnt"}, conflict_cnt, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    // Asynchronous reset asserted mid-cycle, released just after the next rising edge.
    task automatic reset_mid(input string tag);
        fpga_oe = 0; mem_oe = 0;
        #2 reset = 1'b1;
        #1 chk_all_zero(tag);
        model_reset();
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic       foe;
        logic [7:0] fo;
        logic       moe;
        logic [7:0] mo;
        logic       evm;
        logic [7:0] em;
        logic       evf;
        logic [7:0] ef;
        logic [1:0] edir;
        logic       ecf;
        logic [7:0] ecc;
    } vec_t;

    function automatic vec_t v(logic foe, logic [7:0] fo, logic moe, logic [7:0] mo,
                               logic evm, logic [7:0] em, logic evf, logic [7:0] ef,
                               logic [1:0] edir, logic ecf, logic [7:0] ecc);
        vec_t r;
        r.foe = foe; r.fo = fo; r.moe = moe; r.mo = mo; r.evm = evm; r.em = em;
        r.evf = evf; r.ef = ef; r.edir = edir; r.ecf = ecf; r.ecc = ecc;
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        vec_t tv[$];
        logic [7:0] got[$];
        logic [7:0] want[$];
        bit   foe_r = 0, moe_r = 0;

        // write burst, contention in IDLE, oe during TURN, two read bursts
        tv.push_back(v(1,8'h11,0,8'h00, 0,8'h00, 0,8'h00, 0,0,0));
        tv.push_back(v(1,8'h22,0,8'h00, 0,8'h00, 0,8'h00, 1,0,0));
        tv.push_back(v(1,8'h33,0,8'h00, 1,8'h11, 0,8'h00, 1,0,0));
        tv.push_back(v(1,8'h44,0,8'h00, 1,8'h22, 0,8'h00, 1,0,0));
        tv.push_back(v(0,8'h00,0,8'h00, 1,8'h33, 0,8'h00, 1,0,0));
        tv.push_back(v(0,8'h00,0,8'h00, 1,8'h44, 0,8'h00, 1,0,0));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 1,0,0));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 3,0,0));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 3,0,0));
        tv.push_back(v(1,8'h77,1,8'h99, 0,8'h00, 0,8'h00, 0,0,0));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 1,1,1));
        tv.push_back(v(0,8'h00,0,8'h00, 1,8'h77, 0,8'h00, 1,0,1));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 1,0,1));
        tv.push_back(v(0,8'h00,1,8'hC3, 0,8'h00, 0,8'h00, 3,0,1));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 3,1,2));
        tv.push_back(v(0,8'h00,1,8'h3C, 0,8'h00, 0,8'h00, 0,0,2));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 2,0,2));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 2,0,2));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 1,8'h3C, 2,0,2));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 2,0,2));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 3,0,2));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 3,0,2));
        tv.push_back(v(0,8'h00,1,8'hA5, 0,8'h00, 0,8'h00, 0,0,2));
        tv.push_back(v(0,8'h00,1,8'h5A, 0,8'h00, 0,8'h00, 2,0,2));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 2,0,2));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 1,8'hA5, 2,0,2));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 1,8'h5A, 2,0,2));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 2,0,2));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 3,0,2));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 3,0,2));
        tv.push_back(v(0,8'h00,0,8'h00, 0,8'h00, 0,8'h00, 0,0,2));

        m_t = 0;
        model_reset();
        reset = 1'b1;
        @(negedge clock);
        chk_all_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;

        foreach (tv[i]) begin
            drive(tv[i].foe, tv[i].fo, tv[i].moe, tv[i].mo);
            chk("tv_mem_i_vld", mem_i_vld, tv[i].evm);
            chk("tv_mem_i", mem_i, tv[i].em);
            chk("tv_fpga_i_vld", fpga_i_vld, tv[i].evf);
            chk("tv_fpga_i", fpga_i, tv[i].ef);
            chk("tv_dir", dir, tv[i].edir);
            chk("tv_conflict", conflict, tv[i].ecf);
            chk("tv_conflict_cnt", conflict_cnt, tv[i].ecc);
            finish_cycle();
        end

        // two write beats in flight, then reset: nothing may surface afterwards
        cycle(1, 8'hE1, 0, 8'h00);
        cycle(1, 8'hE2, 0, 8'h00);
        reset_mid("midrst");
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 0, 8'h00);
            chk("post_rst_mem_i_vld", mem_i_vld, 0);
            chk("post_rst_dir", dir, 0);
            finish_cycle();
        end

`ifdef DDR_LANE_DELAY_ERR_INSERT_EN
        phy_init_done = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 3 - b; i++) begin
                drive(0, 8'h00, 1, 8'h00);
                if (fpga_i_vld) got.push_back(fpga_i);
                finish_cycle();
            end
            for (int i = 0; i < 8; i++) begin
                drive(0, 8'h00, 0, 8'h00);
                if (fpga_i_vld) got.push_back(fpga_i);
                finish_cycle();
            end
        end
        want = '{8'h08, 8'h00, 8'h00, 8'h08, 8'h00};
        chk("inj_beats", got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++) chk("inj_beat", got[i], want[i]);
        drive(0, 8'h00, 0, 8'h00);
        chk("inj_err_cnt", err_cnt, 2);
        finish_cycle();
        phy_init_done = 1'b0;
`endif

        // sustained contention saturates the counter
        for (int i = 0; i < 300; i++) cycle(1, 8'h5F, 1, 8'hF5);
        drive(0, 8'h00, 0, 8'h00);
        chk("sat_conflict_cnt", conflict_cnt, 255);
        finish_cycle();
        for (int i = 0; i < 10; i++) cycle(0, 8'h00, 0, 8'h00);

        reset_mid("rst2");
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 4) == 0) foe_r = !foe_r;
            if ($urandom_range(0, 4) == 0) moe_r = !moe_r;
            if ($urandom_range(0, 49) == 0) phy_init_done = !phy_init_done;
            cycle(foe_r, 8'($urandom), moe_r, 8'($urandom));
            if (i == 1000) reset_mid("rnd_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
